// File: rtl/inst_fetch_unit_if.sv
// Bus between the fetch unit, the instruction ROM and the datapath.
// master = fetch unit, slave = ROM/datapath side.
interface inst_fetch_unit_if;
    logic [7:0] InstAddress;
    logic [9:0] InstOut;
    logic [3:0] Opcode;
    logic [2:0] Rs;
    logic [2:0] Rt;
    logic       ExecValid;
    logic       Stall;
    logic       CmpEq;

    modport master (
        output InstAddress, Opcode, Rs, Rt, ExecValid,
        input  InstOut, Stall, CmpEq
    );

    modport slave (
        input  InstAddress, Opcode, Rs, Rt, ExecValid,
        output InstOut, Stall, CmpEq
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch/sequence unit: FETCH -> EXEC -> FETCH, or -> HALT on opcode 0000.
// Define INST_FETCH_RETIRE_COUNT_EN to add the saturating RetiredCount output.
module inst_fetch_unit (
    input  logic              Clk,
    input  logic              Reset_n,
    inst_fetch_unit_if.master bus,
    output logic              Halted
`ifdef INST_FETCH_RETIRE_COUNT_EN
    ,
    output logic [15:0]       RetiredCount
`endif
);
    // state   | meaning
    // S_FETCH | latch ROM word into IR (one cycle)
    // S_EXEC  | decoded fields valid; wait for Stall=0, then update PC
    // S_HALT  | terminal until reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [9:0] r_ir;
    logic       r_exec_valid;
    logic       r_halted;
    logic [7:0] w_pc_next;
    logic       w_retire;

    assign w_retire = (r_state == S_EXEC) && !bus.Stall;

    // PC arithmetic wraps naturally at 8 bits.
    always_comb begin
        w_pc_next = r_pc + 8'd1;
        case (r_ir[9:6])
            4'b1001: w_pc_next = {2'b00, r_ir[5:0]};
            4'b1000: w_pc_next = bus.CmpEq ? (r_pc + 8'd1) : (r_pc + 8'd2);
            4'b1100: w_pc_next = bus.CmpEq ? (r_pc + 8'd2) : (r_pc + 8'd1);
            4'b0000: w_pc_next = r_pc;
            default: w_pc_next = r_pc + 8'd1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_FETCH;
            r_pc         <= 8'd0;
            r_ir         <= 10'd0;
            r_exec_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir         <= bus.InstOut;
                    r_state      <= S_EXEC;
                    r_exec_valid <= 1'b1;
                end
                S_EXEC: begin
                    if (!bus.Stall) begin
                        r_pc         <= w_pc_next;
                        r_exec_valid <= 1'b0;
                        if (r_ir[9:6] == 4'b0000) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state      <= S_FETCH;
                    r_exec_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_FETCH_RETIRE_COUNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_retired <= 16'd0;
        end else if (w_retire && (r_retired != 16'hFFFF)) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign RetiredCount = r_retired;
`endif

    assign bus.InstAddress = r_pc;
    assign bus.Opcode      = r_ir[9:6];
    assign bus.Rs          = r_ir[5:3];
    assign bus.Rt          = r_ir[2:0];
    assign bus.ExecValid   = r_exec_valid;
    assign Halted          = r_halted;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: an architectural PC/ROM model predicts each executed
// instruction; a negedge monitor pops and checks address, fields, EXEC length and fetch gap.
module tb_inst_fetch_unit;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Halted;
`ifdef INST_FETCH_RETIRE_COUNT_EN
    logic [15:0] RetiredCount;
`endif

    inst_fetch_unit_if bus();

    inst_fetch_unit dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus),
        .Halted  (Halted)
`ifdef INST_FETCH_RETIRE_COUNT_EN
        ,
        .RetiredCount (RetiredCount)
`endif
    );

    always #5 Clk = ~Clk;

    logic [9:0] rom [256];
    assign bus.InstOut = rom[bus.InstAddress];

    typedef struct {
        logic [7:0] pc;
        logic [9:0] inst;
        int         n_stall;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit   mon_en = 0;
    bit   prev_ev = 0;
    bit   have_cur = 0;
    bit   seen_exec = 0;
    int   ev_len = 0;
    int   gap_len = 0;
    exp_t cur;

    always @(negedge Clk) begin
        if (!mon_en) begin
            prev_ev   = 0;
            have_cur  = 0;
            seen_exec = 0;
            gap_len   = 0;
        end else begin
            if (bus.ExecValid && !prev_ev) begin
                if (q.size() == 0) begin
                    check("unexpected_exec", 1, 0);
                    have_cur = 0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1;
                    check("exec_addr", bus.InstAddress, cur.pc);
                    check("exec_fields", {bus.Opcode, bus.Rs, bus.Rt}, cur.inst);
                    if (seen_exec) check("fetch_gap", gap_len, 1);
                end
                ev_len = 1;
                seen_exec = 1;
            end else if (bus.ExecValid) begin
                ev_len++;
                if (have_cur) begin
                    check("fields_stable", {bus.Opcode, bus.Rs, bus.Rt}, cur.inst);
                    check("pc_stable", bus.InstAddress, cur.pc);
                end
            end else if (prev_ev) begin
                if (have_cur) check("exec_len", ev_len, cur.n_stall + 1);
                gap_len = 1;
            end else begin
                gap_len++;
            end
            prev_ev = bus.ExecValid;
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic fill_noop();
        for (int a = 0; a < 256; a++) rom[a] = {4'b0001, 6'(a)};
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) begin
            logic [3:0] op;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = 4'b1001;
                1: op = 4'b1000;
                2: op = 4'b1100;
                default: op = 4'($urandom_range(1, 15));
            endcase
            rom[a] = {op, 6'($urandom)};
        end
    endtask

    // cmp_mode: 0 random, 1 force CmpEq=0, 2 force CmpEq=1 on the release cycle
    task automatic run_program(input int n_instr, input int cmp_mode,
                               input int stall_min, input int stall_max);
        logic [7:0] pc;
        logic [9:0] inst;
        int  n;
        int  to;
        int  retired;
        bit  cmp;
        bit  model_halt;
        bit  aborted;
        pc = 8'd0;
        retired = 0;
        model_halt = 0;
        aborted = 0;
        mon_en = 0;
        bus.Stall = 1'b0;
        bus.CmpEq = 1'b0;
        Reset_n = 1'b0;
        q.delete();
        @(negedge Clk);
        @(negedge Clk);
        check("rst_exec_valid", bus.ExecValid, 0);
        check("rst_halted", Halted, 0);
        check("rst_addr", bus.InstAddress, 0);
        check("rst_fields", {bus.Opcode, bus.Rs, bus.Rt}, 0);
`ifdef INST_FETCH_RETIRE_COUNT_EN
        check("rst_retired", RetiredCount, 0);
`endif
        for (int k = 0; k < n_instr; k++) begin
            if (k == n_instr - 1 && rom[pc][9:6] != 4'b0000) rom[pc] = {4'b0000, 6'($urandom)};
            inst = rom[pc];
            n = $urandom_range(stall_min, stall_max);
            cmp = (cmp_mode == 0) ? 1'($urandom) : (cmp_mode == 2);
            q.push_back('{pc: pc, inst: inst, n_stall: n});
            if (k == 0) begin
                mon_en = 1;
                Reset_n = 1'b1;
            end
            to = 0;
            do begin
                @(negedge Clk);
                to++;
            end while (!bus.ExecValid && to < 10);
            if (!bus.ExecValid) begin
                check("exec_timeout", 0, 1);
                aborted = 1;
                break;
            end
            for (int s = 0; s < n; s++) begin
                bus.Stall = 1'b1;
                bus.CmpEq = 1'($urandom);
                @(negedge Clk);
            end
            bus.Stall = 1'b0;
            bus.CmpEq = cmp;
            retired++;
            case (inst[9:6])
                4'b0000: model_halt = 1;
                4'b1001: pc = {2'b00, inst[5:0]};
                4'b1000: pc = pc + (cmp ? 8'd1 : 8'd2);
                4'b1100: pc = pc + (cmp ? 8'd2 : 8'd1);
                default: pc = pc + 8'd1;
            endcase
            if (model_halt) break;
        end
        if (!aborted) begin
            for (int h = 0; h < 5; h++) begin
                @(negedge Clk);
                check("halted", Halted, 1);
                check("halt_exec_valid", bus.ExecValid, 0);
                check("halt_pc", bus.InstAddress, pc);
`ifdef INST_FETCH_RETIRE_COUNT_EN
                check("retired_count", RetiredCount, retired);
`endif
                bus.Stall = 1'($urandom);
                bus.CmpEq = 1'($urandom);
            end
            check("queue_drained", q.size(), 0);
        end
        mon_en = 0;
        bus.Stall = 1'b0;
    endtask

    task automatic mid_exec_reset();
        int to;
        mon_en = 0;
        fill_noop();
        rom[0] = {4'b1001, 6'd40};
        bus.Stall = 1'b0;
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        to = 0;
        do begin
            @(negedge Clk);
            to++;
        end while (!(bus.ExecValid && bus.InstAddress == 8'd40) && to < 10);
        check("mid_reach_40", bus.InstAddress, 40);
        bus.Stall = 1'b1;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_exec_valid", bus.ExecValid, 0);
        check("mid_rst_addr", bus.InstAddress, 0);
        check("mid_rst_fields", {bus.Opcode, bus.Rs, bus.Rt}, 0);
        @(negedge Clk);
        bus.Stall = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post_rst_exec", bus.ExecValid, 1);
        check("post_rst_addr", bus.InstAddress, 0);
        check("post_rst_fields", {bus.Opcode, bus.Rs, bus.Rt}, {4'b1001, 6'd40});
    endtask

    initial begin
        bus.Stall = 1'b0;
        bus.CmpEq = 1'b0;

        fill_noop();
        rom[0] = 10'b0100111111;
        rom[1] = 10'b0110000111;
        rom[2] = 10'b0000010111;
        run_program(3, 0, 0, 0);

        fill_noop();
        rom[0] = {4'b1001, 6'd7};
        rom[7] = {4'b1000, 6'd0};
        run_program(3, 2, 0, 0);
        fill_noop();
        rom[0] = {4'b1001, 6'd7};
        rom[7] = {4'b1000, 6'd0};
        run_program(3, 1, 0, 0);
        fill_noop();
        rom[0]  = {4'b1001, 6'd11};
        rom[11] = {4'b1100, 6'd0};
        run_program(3, 2, 0, 0);

        fill_noop();
        rom[0] = {4'b1100, 6'b010011};
        run_program(2, 2, 3, 3);

        fill_noop();
        rom[0] = 10'b1001010110;
        run_program(2, 0, 0, 1);

        fill_noop();
        rom[0] = {4'b1001, 6'd60};
        run_program(198, 1, 0, 0);
        fill_noop();
        rom[0]   = {4'b1001, 6'd60};
        rom[254] = {4'b1000, 6'd0};
        run_program(197, 1, 0, 0);
        fill_noop();
        rom[0]   = {4'b1001, 6'd60};
        rom[255] = {4'b1000, 6'd0};
        run_program(198, 1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_program(60, 0, 0, 3);
        end

`ifdef INST_FETCH_RETIRE_COUNT_EN
        fill_random();
        run_program(25, 0, 0, 0);
`endif

        mid_exec_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
